// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: CRC-15 constants, state encoding and
// the single-bit CRC-15 LFSR step.
package can_pkg;

    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
    localparam int unsigned CAN_STUFF_LEN = 5;
    localparam int unsigned CAN_CRC_LEN   = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COVER  = 2'd1,
        CRCSEQ = 2'd2,
        DELIM  = 2'd3
    } can_state_e;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        logic n;
        n = b ^ crc[14];
        return {crc[13:0], 1'b0} ^ (n ? CAN_CRC_POLY : 15'h0000);
    endfunction

endpackage

// File: rtl/can_crc_check_destuff.sv
// Bit-destuffing run tracker: flags the bit after five equal bits as a stuff
// bit and reports a violation when that bit repeats the run value.
module can_destuff
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic start,
    input  logic shift,
    input  logic rx_bit,
    output logic pend,
    output logic viol,
    output logic fill_nxt
);
    localparam logic [2:0] RUN_FULL = 3'(CAN_STUFF_LEN);

    logic [2:0] run_q, run_d;
    logic       last_q, last_d;

    assign pend     = (run_q == RUN_FULL);
    assign viol     = pend && (rx_bit == last_q);
    // this non-stuff bit completes a run, so the following bit must be stuff
    assign fill_nxt = !pend && (rx_bit == last_q) && (run_q == (RUN_FULL - 3'd1));

    // next run length / last value
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (clr) begin
            run_d  = 3'd0;
            last_d = 1'b0;
        end else if (start) begin
            run_d  = 3'd1;
            last_d = 1'b0;
        end else if (shift) begin
            run_d  = (pend || (rx_bit != last_q)) ? 3'd1 : (run_q + 3'd1);
            last_d = rx_bit;
        end else begin
            run_d  = run_q;
            last_d = last_q;
        end
    end

    // run state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 3'd0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_crc_check.sv
// CAN receive CRC-15 checker: destuffs sampled bits, forwards them, checks the
// CRC remainder and the CRC delimiter.
module can_crc_check
    import can_pkg::*;
#(
    parameter logic [14:0] CRC_INIT = 15'h0000,
    parameter int unsigned MAX_COV  = 103
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_valid,
    input  logic       rx_bit,
    input  logic       sof,
    input  logic       abort,
    input  logic [6:0] cov_len,
    input  logic       cov_len_vld,
    output logic       dbit_valid,
    output logic       dbit,
    output logic       busy,
    output logic       crc_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       stuff_err,
    output logic       form_err
);
    localparam logic [6:0] MAX_COV_W = 7'(MAX_COV);
    localparam logic [3:0] CRC_LAST  = 4'(CAN_CRC_LEN - 1);
    localparam logic [3:0] CRC_HOLD  = 4'(CAN_CRC_LEN);

    can_state_e  state_q, state_d;
    logic [14:0] crc_q, crc_d;
    logic [6:0]  cnt_q, cnt_d, len_q, len_d;
    logic        len_vld_q, len_vld_d;
    logic [3:0]  crc_cnt_q, crc_cnt_d;
    logic        dbit_valid_q, dbit_valid_d, dbit_q, dbit_d, busy_q, busy_d;
    logic        crc_done_q, crc_done_d, crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;
    logic        stuff_err_q, stuff_err_d, form_err_q, form_err_d;

    logic       ds_start, ds_shift, ds_clr, ds_pend, ds_viol, ds_fill;
    logic       took, len_vld_eff;
    logic [6:0] cnt_cmp, len_eff;

    can_destuff u_destuff (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ds_clr),
        .start    (ds_start),
        .shift    (ds_shift),
        .rx_bit   (rx_bit),
        .pend     (ds_pend),
        .viol     (ds_viol),
        .fill_nxt (ds_fill)
    );

    // frame sequencing, CRC update and strobe generation
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        len_vld_d    = len_vld_q;
        crc_cnt_d    = crc_cnt_q;
        dbit_valid_d = 1'b0;
        dbit_d       = dbit_q;
        crc_done_d   = 1'b0;
        crc_ok_d     = 1'b0;
        crc_err_d    = crc_err_q;
        stuff_err_d  = 1'b0;
        form_err_d   = 1'b0;
        ds_start     = 1'b0;
        ds_shift     = 1'b0;
        took         = bit_valid && !ds_pend;
        cnt_cmp      = took ? (cnt_q + 7'd1) : cnt_q;
        // a length strobe coinciding with a bit is compared immediately
        len_eff      = cov_len_vld ? cov_len : len_q;
        len_vld_eff  = cov_len_vld || len_vld_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_valid && sof && !rx_bit) begin
                        state_d      = COVER;
                        crc_d        = crc_step(CRC_INIT, 1'b0);
                        cnt_d        = 7'd1;
                        len_vld_d    = 1'b0;
                        crc_err_d    = 1'b0;
                        ds_start     = 1'b1;
                        dbit_valid_d = 1'b1;
                        dbit_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                COVER: begin
                    ds_shift = bit_valid;
                    if (cov_len_vld) begin
                        len_d     = cov_len;
                        len_vld_d = 1'b1;
                    end else begin
                        len_d = len_q;
                    end
                    if (bit_valid && ds_viol) begin
                        stuff_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        if (took) begin
                            dbit_valid_d = 1'b1;
                            dbit_d       = rx_bit;
                            crc_d        = crc_step(crc_q, rx_bit);
                            cnt_d        = cnt_cmp;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (took || cov_len_vld) begin
                            if (len_vld_eff && (len_eff == cnt_cmp)) begin
                                state_d   = CRCSEQ;
                                crc_cnt_d = 4'd0;
                            end else if ((len_vld_eff && (len_eff < cnt_cmp)) ||
                                         (cnt_cmp >= MAX_COV_W)) begin
                                form_err_d = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                state_d = COVER;
                            end
                        end else begin
                            state_d = COVER;
                        end
                    end
                end
                CRCSEQ: begin
                    ds_shift = bit_valid;
                    if (!bit_valid) begin
                        state_d = CRCSEQ;
                    end else if (ds_viol) begin
                        stuff_err_d = 1'b1;
                        state_d     = IDLE;
                    end else if (ds_pend) begin
                        // a stuff bit owed after the last CRC bit closes the sequence
                        state_d = (crc_cnt_q == CRC_HOLD) ? DELIM : CRCSEQ;
                    end else begin
                        dbit_valid_d = 1'b1;
                        dbit_d       = rx_bit;
                        crc_d        = crc_step(crc_q, rx_bit);
                        crc_cnt_d    = crc_cnt_q + 4'd1;
                        if ((crc_cnt_q == CRC_LAST) && !ds_fill) begin
                            state_d = DELIM;
                        end else begin
                            state_d = CRCSEQ;
                        end
                    end
                end
                DELIM: begin
                    if (bit_valid) begin
                        crc_done_d = 1'b1;
                        crc_err_d  = (crc_q != 15'h0000);
                        crc_ok_d   = (crc_q == 15'h0000) && rx_bit;
                        form_err_d = !rx_bit;
                        state_d    = IDLE;
                    end else begin
                        state_d = DELIM;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ds_clr = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            cnt_q        <= 7'd0;
            len_q        <= 7'd0;
            len_vld_q    <= 1'b0;
            crc_cnt_q    <= 4'd0;
            dbit_valid_q <= 1'b0;
            dbit_q       <= 1'b0;
            busy_q       <= 1'b0;
            crc_done_q   <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
            stuff_err_q  <= 1'b0;
            form_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            len_vld_q    <= len_vld_d;
            crc_cnt_q    <= crc_cnt_d;
            dbit_valid_q <= dbit_valid_d;
            dbit_q       <= dbit_d;
            busy_q       <= busy_d;
            crc_done_q   <= crc_done_d;
            crc_ok_q     <= crc_ok_d;
            crc_err_q    <= crc_err_d;
            stuff_err_q  <= stuff_err_d;
            form_err_q   <= form_err_d;
        end
    end

    assign dbit_valid = dbit_valid_q;
    assign dbit       = dbit_q;
    assign busy       = busy_q;
    assign crc_done   = crc_done_q;
    assign crc_ok     = crc_ok_q;
    assign crc_err    = crc_err_q;
    assign stuff_err  = stuff_err_q;
    assign form_err   = form_err_q;

endmodule

// File: tb/tb_can_crc_check.sv
// Randomized and directed bench for can_crc_check against a frame-level model
// built on raw-bit history and destuffed-bit queues.
module tb_can_crc_check;

    logic       clk = 1'b0;
    logic       rst_n, bit_valid, rx_bit, sof, abort, cov_len_vld;
    logic [6:0] cov_len;
    logic       dbit_valid, dbit, busy, crc_done, crc_ok, crc_err, stuff_err, form_err;

    always #5 clk = ~clk;

    can_crc_check dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit), .sof(sof),
        .abort(abort), .cov_len(cov_len), .cov_len_vld(cov_len_vld),
        .dbit_valid(dbit_valid), .dbit(dbit), .busy(busy), .crc_done(crc_done),
        .crc_ok(crc_ok), .crc_err(crc_err), .stuff_err(stuff_err), .form_err(form_err)
    );

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 covered bits, 2 crc sequence, 3 delimiter
    int m_phase;
    bit m_raw[$];
    bit m_dq[$];
    bit m_len_known;
    int m_len;
    bit m_err;
    bit e_dv, e_db, e_busy, e_done, e_ok, e_err, e_serr, e_ferr;

    int n_dv, n_done, n_ok, n_ferr, n_serr;
    bit frm_q[$];
    bit raw_q[$];

    function automatic logic [14:0] crc15(input bit q[$]);
        logic [14:0] r;
        logic        n;
        r = 15'h0000;
        foreach (q[i]) begin
            n = q[i] ^ r[14];
            r = {r[13:0], 1'b0};
            if (n) r = r ^ 15'h4599;
        end
        return r;
    endfunction

    function automatic bit trail5();
        int n;
        n = m_raw.size();
        if (n < 5) return 1'b0;
        return (m_raw[n-1] == m_raw[n-2]) && (m_raw[n-2] == m_raw[n-3]) &&
               (m_raw[n-3] == m_raw[n-4]) && (m_raw[n-4] == m_raw[n-5]);
    endfunction

    function automatic void mreset();
        m_phase = 0; m_err = 1'b0;
        e_dv = 1'b0; e_db = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_ok = 1'b0; e_err = 1'b0; e_serr = 1'b0; e_ferr = 1'b0;
    endfunction

    function automatic void model_step(input bit bv, input bit b, input bit s, input bit ab,
                                       input bit lv, input int len);
        bit stuffpos, took;
        e_dv = 1'b0; e_done = 1'b0; e_ok = 1'b0; e_serr = 1'b0; e_ferr = 1'b0;
        if (ab) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (bv && s && !b) begin
                    m_phase = 1; m_raw = {}; m_dq = {};
                    m_raw.push_back(b); m_dq.push_back(b);
                    m_err = 1'b0; m_len_known = 1'b0; e_dv = 1'b1; e_db = b;
                end
                1, 2: begin
                    stuffpos = trail5();
                    took = 1'b0;
                    if (m_phase == 1 && lv) begin m_len_known = 1'b1; m_len = len; end
                    if (bv && stuffpos && b == m_raw[$]) begin
                        e_serr = 1'b1; m_phase = 0;
                    end else begin
                        if (bv) begin
                            m_raw.push_back(b);
                            if (!stuffpos) begin m_dq.push_back(b); took = 1'b1; e_dv = 1'b1; e_db = b; end
                        end
                        if (m_phase == 1) begin
                            if (took || lv) begin
                                if (m_len_known && m_len == m_dq.size()) m_phase = 2;
                                else if ((m_len_known && m_len < m_dq.size()) || m_dq.size() >= 103) begin
                                    e_ferr = 1'b1; m_phase = 0;
                                end
                            end
                        end else if (bv && m_dq.size() == m_len + 15 && !trail5()) begin
                            m_phase = 3;
                        end
                    end
                end
                3: if (bv) begin
                    e_done = 1'b1;
                    m_err  = (crc15(m_dq) != 15'h0000);
                    e_ok   = !m_err && b;
                    e_ferr = !b;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        e_err  = m_err;
        e_busy = (m_phase != 0);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("dbit_valid", dbit_valid, e_dv);
        if (e_dv) chk("dbit", dbit, e_db);
        chk("busy", busy, e_busy);
        chk("crc_done", crc_done, e_done);
        chk("crc_ok", crc_ok, e_ok);
        chk("crc_err", crc_err, e_err);
        chk("stuff_err", stuff_err, e_serr);
        chk("form_err", form_err, e_ferr);
        n_dv += int'(dbit_valid); n_done += int'(crc_done); n_ok += int'(crc_ok);
        n_ferr += int'(form_err); n_serr += int'(stuff_err);
    endtask

    task automatic clr_stats();
        n_dv = 0; n_done = 0; n_ok = 0; n_ferr = 0; n_serr = 0;
    endtask

    task automatic cyc(input bit bv, input bit b, input bit s, input bit ab, input bit lv,
                       input logic [6:0] len);
        bit_valid = bv; rx_bit = b; sof = s; abort = ab; cov_len_vld = lv; cov_len = len;
        model_step(bv, b, s, ab, lv, int'(len));
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bit_valid = 1'b0; sof = 1'b0; abort = 1'b0; cov_len_vld = 1'b0;
        #1;
        mreset();
        compare();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    // stuff frm_q (covered + crc bits) into raw_q and append the delimiter
    function automatic void build_raw(input bit delim);
        int run;
        bit last;
        raw_q = {}; run = 0; last = 1'b0;
        foreach (frm_q[i]) begin
            if (run == 5) begin raw_q.push_back(!last); last = !last; run = 1; end
            raw_q.push_back(frm_q[i]);
            if (run > 0 && frm_q[i] == last) run++; else run = 1;
            last = frm_q[i];
        end
        if (run == 5) raw_q.push_back(!last);
        raw_q.push_back(delim);
    endfunction

    function automatic void zero_frame();
        frm_q = {};
        for (int i = 0; i < 34; i++) frm_q.push_back(1'b0);
    endfunction

    // mode 0 normal, 1 abort at stop_at, 2 reset at stop_at
    task automatic send(input int lv_at, input bit lv_gap, input logic [6:0] len, input int mode,
                        input int stop_at, input int gapmax, input bit rnd_sof);
        bit s;
        clr_stats();
        for (int i = 0; i < raw_q.size(); i++) begin
            if (i == stop_at && mode == 1) begin cyc(1'b1, raw_q[i], 1'b0, 1'b1, 1'b0, 7'd0); break; end
            if (i == stop_at && mode == 2) begin do_reset(); break; end
            if (i == lv_at && lv_gap) cyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1, len);
            s = (i == 0) || (rnd_sof && $urandom_range(19, 0) == 0);
            cyc(1'b1, raw_q[i], s, 1'b0, (i == lv_at) && !lv_gap, len);
            repeat ($urandom_range(gapmax, 0)) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 7'd0);
        end
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    endtask

    initial begin
        bit q[$];
        logic [14:0] c;
        int len_cov, mode, idx;
        rst_n = 1'b0; bit_valid = 1'b0; rx_bit = 1'b1; sof = 1'b0; abort = 1'b0;
        cov_len_vld = 1'b0; cov_len = 7'd0;
        mreset(); clr_stats();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // model pins
        q = {}; q.push_back(1'b1);
        chkn("crc_pin_1", int'(crc15(q)), 32'h4599);
        q.push_back(1'b0);
        chkn("crc_pin_10", int'(crc15(q)), 32'h4EAB);
        q = {}; q.push_back(1'b0);
        for (int i = 0; i < 30; i++) q.push_back(1'($urandom));
        c = crc15(q);
        for (int i = 14; i >= 0; i--) q.push_back(c[i]);
        chkn("crc_pin_zero_rem", int'(crc15(q)), 0);

        // all-zero standard frame, length strobed between bits after count 12
        zero_frame(); build_raw(1'b1);
        send(14, 1'b1, 7'd19, 0, -1, 0, 1'b0);
        chkn("f1_dbits", n_dv, 34); chkn("f1_done", n_done, 1); chkn("f1_ok", n_ok, 1);
        chk("f1_crc_err", crc_err, 1'b0);

        // covered bit 8 flipped, received CRC unchanged
        zero_frame(); frm_q[8] = 1'b1; build_raw(1'b1);
        send(14, 1'b1, 7'd19, 0, -1, 1, 1'b0);
        chkn("f2_done", n_done, 1); chkn("f2_ok", n_ok, 0); chk("f2_crc_err", crc_err, 1'b1);

        // six zeros from SOF without a stuff bit
        clr_stats();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        chkn("f3_stuff_err", n_serr, 1); chk("f3_busy", busy, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        chkn("f3_done", n_done, 0);

        // dominant delimiter
        zero_frame(); build_raw(1'b0);
        send(14, 1'b1, 7'd19, 0, -1, 0, 1'b0);
        chkn("f4_done", n_done, 1); chkn("f4_form", n_ferr, 1); chkn("f4_ok", n_ok, 0);

        // no length strobe: overrun at 103 destuffed bits
        frm_q = {}; frm_q.push_back(1'b0);
        for (int i = 1; i < 110; i++) frm_q.push_back(1'($urandom));
        build_raw(1'b1);
        send(-1, 1'b0, 7'd0, 0, -1, 0, 1'b0);
        chkn("f5_form", n_ferr, 1); chkn("f5_dbits", n_dv, 103); chkn("f5_done", n_done, 0);
        chk("f5_busy", busy, 1'b0);

        // abort at covered bit 10
        zero_frame(); build_raw(1'b1);
        send(14, 1'b1, 7'd19, 1, 10, 0, 1'b0);
        chk("f6_busy", busy, 1'b0); chkn("f6_done", n_done, 0);
        chkn("f6_errs", n_ferr + n_serr, 0);

        // reset during the CRC sequence, then a complete frame
        zero_frame(); build_raw(1'b1);
        send(14, 1'b1, 7'd19, 2, 28, 0, 1'b0);
        send(14, 1'b1, 7'd19, 0, -1, 0, 1'b0);
        chkn("f7_ok", n_ok, 1); chkn("f7_dbits", n_dv, 34);

        // randomized frames with assorted corruptions
        for (int f = 0; f < 60; f++) begin
            len_cov = $urandom_range(103, 19);
            frm_q = {}; frm_q.push_back(1'b0);
            for (int i = 1; i < len_cov; i++) frm_q.push_back(1'($urandom));
            c = crc15(frm_q);
            for (int i = 14; i >= 0; i--) frm_q.push_back(c[i]);
            mode = $urandom_range(6, 0);
            build_raw(mode != 2);
            if (mode == 1) begin
                idx = $urandom_range(raw_q.size() - 1, 1);
                raw_q[idx] = !raw_q[idx];
            end
            case (mode)
                3: send(-1, 1'b0, 7'd0, 0, -1, 2, 1'b1);
                4: send($urandom_range(10, 1), 1'($urandom), 7'(len_cov), 1,
                        $urandom_range(raw_q.size() - 1, 1), 2, 1'b1);
                5: send($urandom_range(10, 1), 1'($urandom), 7'($urandom_range(120, 1)), 0, -1, 2, 1'b1);
                default: send($urandom_range(10, 1), 1'($urandom), 7'(len_cov), 0, -1, 2, 1'b1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_crc_check.md
Name: can_crc_check

Overview:
- Receive-side counterpart of the CAN CRC-15 generator. Takes raw sampled bus bits, removes stuff bits, and forwards destuffed bits to the frame decoder.
- Runs CRC-15 (poly 0x4599) over SOF..data end, then feeds the received 15-bit CRC sequence through the same LFSR and requires a zero remainder.
- Checks the CRC delimiter. Sits between the bit-timing sampler and the RX frame decoder.

Parameters:
- CRC_INIT, 15'h0000, LFSR seed loaded at SOF.
- MAX_COV, 103, max covered bits (extended frame, 8 data bytes); overrun limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bit_valid  in  1  one-cycle strobe per sampled bus bit
- rx_bit  in  1  sampled bit (0 = dominant)
- sof  in  1  qualifies bit_valid: this bit is SOF; starts a frame
- abort  in  1  drop current frame, return to IDLE
- cov_len  in  7  number of destuffed CRC-covered bits incl. SOF
- cov_len_vld  in  1  one-cycle strobe; latches cov_len
- dbit_valid  out  1  strobe: destuffed bit available
- dbit  out  1  destuffed bit
- busy  out  1  high in any state other than IDLE
- crc_done  out  1  one-cycle strobe on delimiter bit
- crc_ok  out  1  valid with crc_done: remainder zero and delimiter recessive
- crc_err  out  1  sticky per frame: remainder nonzero
- stuff_err  out  1  one-cycle strobe: stuff rule violated
- form_err  out  1  one-cycle strobe: delimiter dominant, or covered-length overrun

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR = CRC_INIT, run count 0.
- All outputs are registered, one clk after the bit_valid that caused them.
- Bits with bit_valid low are ignored.
- States:
  - IDLE
  - COVER: covered bits
  - CRCSEQ: 15 CRC bits
  - DELIM: delimiter
- IDLE -> COVER on bit_valid & sof & rx_bit==0.
  - LFSR seeded with CRC_INIT, then SOF is shifted in.
  - Destuffed count = 1, run = 1, last = 0, crc_err cleared.
  - sof with rx_bit==1 is ignored.
- LFSR step per destuffed bit b: n = b ^ crc[14]; crc = {crc[13:0],0} ^ (n ? 15'h4599 : 0).
- Destuffing in COVER and CRCSEQ:
  - When run==5, the next bit is a stuff bit. It is not forwarded and not shifted into the LFSR.
  - If the stuff bit equals last: stuff_err pulse, go to IDLE.
  - Otherwise run=1, last=stuff bit.
  - Any non-stuff bit: run = (bit==last) ? run+1 : 1; last = bit.
- COVER:
  - Each destuffed bit: dbit_valid pulse, LFSR step, count++.
  - Once the count equals the latched cov_len: go to CRCSEQ, CRC counter = 0.
  - count reaching MAX_COV with no cov_len latched, or latched cov_len < current count: form_err pulse, go to IDLE.
- cov_len_vld is accepted only in COVER. It may coincide with a bit strobe; the comparison uses the newly latched value.
- CRCSEQ:
  - Destuffed bits are forwarded and shifted into the LFSR.
  - After the 15th, go to DELIM with the run state kept.
  - If run==5 after the 15th bit, the one pending stuff bit is consumed (checked as above) before DELIM.
- DELIM (no destuffing):
  - Next bit: crc_done pulse.
  - crc_err = (LFSR != 0).
  - If the bit is 0: form_err pulse.
  - crc_ok = !crc_err & bit==1.
  - Go to IDLE.
- abort: in any state, to IDLE next clk; no crc_done. abort wins over a simultaneous bit_valid.
- sof while busy is ignored; the frame continues.
- rst_n mid-frame: immediate return to reset values.

Decomposition:
- Shared package can_pkg holds:
  - CAN_CRC_POLY = 15'h4599
  - CAN_STUFF_LEN = 5
  - CAN_CRC_LEN = 15
  - state enum {IDLE, COVER, CRCSEQ, DELIM}
- One natural sub-module: can_destuff (run counter, stuff-bit drop, stuff_err). Reused by the TX monitor.
- The LFSR stays inline.

Test Plan:
- Std frame, ID 0x000, RTR 0, DLC 0: 19 zero covered bits (cov_len=19, strobed at count 12), CRC 15'h0000. Raw stream has a stuff 1 after every 5 zeros, delimiter 1 -> 19+15 dbit pulses, crc_done with crc_ok=1, crc_err=0.
- Same frame with covered bit 8 flipped to 1 (stuffing recomputed) -> crc_done, crc_ok=0, crc_err=1.
- Six consecutive 0s after SOF (no stuff bit) -> stuff_err pulse one clk after the 6th bit; busy=0; no crc_done.
- Valid frame with delimiter 0 -> crc_done, form_err=1, crc_ok=0.
- No cov_len_vld, 103 destuffed bits -> form_err on the 103rd, IDLE. Separately: abort at covered bit 10 -> busy=0 next clk, no strobes.
- rst_n low during CRCSEQ, then a full valid frame -> all outputs 0 during reset; second frame ends with crc_ok=1.
